// File: rtl/blackjack_fsm.sv
// Purpose: blackjack referee that tracks the deal, player hits and dealer draws, then declares the result.
// Latency: result outputs and DSTAY rise one clock after the D_CHECK decision; DHIT pulses one clock per dealer card.
// Backpressure: none; deal and player states stall until HIT, and dealer draws are paced by DHIT.
module blackjack_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic       stay,
    input  logic       hit,
    input  logic [3:0] card,
    output logic       win,
    output logic       lose,
    output logic       tie,
    output logic       dhit,
    output logic       dstay
);

    typedef enum logic [2:0] {
        DEAL_P1,
        DEAL_D1,
        DEAL_P2,
        DEAL_D2,
        PLAYER,
        D_CHECK,
        D_HIT,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] ps;
    logic [5:0] ds;
    logic       hit_q;

    // Hand sums clamp at 63 so a long run of cards can never wrap back into range.
    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [3:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {3'b000, b};
        return s[6] ? 6'd63 : s[5:0];
    endfunction

    // Game sequencer: state, hand sums, HIT edge history and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= DEAL_P1;
            ps    <= 6'd0;
            ds    <= 6'd0;
            hit_q <= 1'b0;
            dhit  <= 1'b0;
            dstay <= 1'b0;
            win   <= 1'b0;
            lose  <= 1'b0;
            tie   <= 1'b0;
        end else begin
            hit_q <= hit;
            case (state)
                DEAL_P1: begin
                    if (hit) begin
                        ps    <= sat_add(ps, card);
                        state <= DEAL_D1;
                    end
                end
                DEAL_D1: begin
                    if (hit) begin
                        ds    <= sat_add(ds, card);
                        state <= DEAL_P2;
                    end
                end
                DEAL_P2: begin
                    if (hit) begin
                        ps    <= sat_add(ps, card);
                        state <= DEAL_D2;
                    end
                end
                DEAL_D2: begin
                    if (hit) begin
                        ds    <= sat_add(ds, card);
                        state <= PLAYER;
                    end
                end
                PLAYER: begin
                    // Standing wins over a coincident HIT rise; a held HIT yields one card.
                    if (stay) begin
                        state <= D_CHECK;
                    end else if (hit && !hit_q) begin
                        ps <= sat_add(ps, card);
                    end
                end
                D_CHECK: begin
                    if (ps > 6'd21 || ds >= 6'd17) begin
                        state <= DONE;
                        dstay <= 1'b1;
                        if (ps > 6'd21) begin
                            lose <= 1'b1;
                        end else if (ds > 6'd21) begin
                            win <= 1'b1;
                        end else if (ps > ds) begin
                            win <= 1'b1;
                        end else if (ps < ds) begin
                            lose <= 1'b1;
                        end else begin
                            tie <= 1'b1;
                        end
                    end else begin
                        ds    <= sat_add(ds, card);
                        dhit  <= 1'b1;
                        state <= D_HIT;
                    end
                end
                D_HIT: begin
                    dhit  <= 1'b0;
                    state <= D_CHECK;
                end
                DONE: begin
                    // Result is final until reset.
                    state <= DONE;
                end
                default: begin
                    state <= DEAL_P1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_blackjack_fsm.sv
// Purpose: self-checking bench for blackjack_fsm; expected game results queued at stimulus time, compared at DSTAY.
// Latency: checks the STAY-to-DSTAY cycle count and the DHIT pulse count of every game.
// Backpressure: bench acts as dealer shoe, presenting the next card after each DHIT pulse.
module tb_blackjack_fsm;

    logic       clk;
    logic       reset;
    logic       stay;
    logic       hit;
    logic [3:0] card;
    logic       win;
    logic       lose;
    logic       tie;
    logic       dhit;
    logic       dstay;

    int n_checks;
    int n_fail;

    typedef struct {
        int win;
        int lose;
        int tie;
        int dh;
        int lat;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] p_q[$];
    logic [3:0] d_q[$];

    blackjack_fsm dut (
        .clk   (clk),
        .reset (reset),
        .stay  (stay),
        .hit   (hit),
        .card  (card),
        .win   (win),
        .lose  (lose),
        .tie   (tie),
        .dhit  (dhit),
        .dstay (dstay)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One-cycle HIT strobe with a card.
    task automatic pulse(input logic [3:0] c);
        hit  = 1'b1;
        card = c;
        @(negedge clk);
        hit  = 1'b0;
        card = 4'd0;
    endtask

    task automatic play(input string name,
                        input logic [3:0] p1, input logic [3:0] d1,
                        input logic [3:0] p2, input logic [3:0] d2,
                        input logic stay_in_deal, input logic hold,
                        input int e_win, input int e_lose, input int e_tie,
                        input int e_dh, input int e_lat);
        exp_t e;
        exp_t got;
        int   cycles;
        int   dh;
        int   idx;
        int   early;
        e.win = e_win; e.lose = e_lose; e.tie = e_tie; e.dh = e_dh; e.lat = e_lat;
        sb.push_back(e);

        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        stay  = stay_in_deal;

        pulse(p1);
        pulse(d1);
        pulse(p2);
        pulse(d2);

        foreach (p_q[i]) begin
            @(negedge clk);
            pulse(p_q[i]);
        end
        if (hold) begin
            @(negedge clk);
            hit  = 1'b1;
            card = 4'd10;
            repeat (4) @(negedge clk);
            hit  = 1'b0;
            card = 4'd0;
            @(negedge clk);
            hit  = 1'b1;
            card = 4'd9;
        end
        stay = 1'b1;
        if (d_q.size() > 0) card = d_q[0];
        idx    = 1;
        cycles = 0;
        dh     = 0;
        early  = 0;
        while (cycles < 200) begin
            @(negedge clk);
            cycles++;
            hit = 1'b0;
            if (dstay) break;
            if (win || lose || tie) early = 1;
            if (dhit) begin
                dh++;
                card = (idx < d_q.size()) ? d_q[idx] : 4'd0;
                idx++;
            end
        end
        stay = 1'b0;
        check({name, " dstay"}, int'(dstay), 1);
        got = sb.pop_front();
        check({name, " win"},   int'(win),  got.win);
        check({name, " lose"},  int'(lose), got.lose);
        check({name, " tie"},   int'(tie),  got.tie);
        check({name, " dhits"}, dh,         got.dh);
        check({name, " lat"},   cycles,     got.lat);
        check({name, " early"}, early,      0);
        hit  = 1'b1;
        card = 4'd15;
        repeat (3) @(negedge clk);
        hit  = 1'b0;
        card = 4'd0;
        check({name, " held"}, int'({dstay, win, lose, tie}),
              int'({1'b1, got.win[0], got.lose[0], got.tie[0]}));
    endtask

    initial begin
        int wait_cnt;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        stay  = 1'b0;
        hit   = 1'b0;
        card  = 4'd0;
        #1;
        check("rst outputs", int'({win, lose, tie, dhit, dstay}), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        p_q = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3};
        d_q.delete();
        play("g027", 1, 9, 1, 9, 1'b0, 1'b0, 1, 0, 0, 0, 2);

        p_q.delete();
        d_q = '{4'd2, 4'd1, 4'd2, 4'd1, 4'd2, 4'd2, 4'd3, 4'd6};
        play("g028", 9, 1, 9, 1, 1'b0, 1'b0, 0, 1, 0, 8, 18);

        p_q = '{4'd2, 4'd4, 4'd1, 4'd2};
        d_q = '{4'd1, 4'd1, 4'd1, 4'd3, 4'd3, 4'd9};
        play("g029", 5, 3, 5, 4, 1'b0, 1'b0, 1, 0, 0, 6, 14);

        p_q = '{4'd7, 4'd10};
        d_q.delete();
        play("g030", 5, 3, 5, 4, 1'b0, 1'b0, 0, 1, 0, 0, 2);

        // STAY held through the whole deal must not disturb it.
        p_q.delete();
        d_q = '{4'd1};
        play("g031", 9, 7, 8, 9, 1'b1, 1'b0, 0, 0, 1, 1, 4);

        p_q.delete();
        d_q.delete();
        play("g032", 11, 10, 10, 11, 1'b0, 1'b0, 0, 0, 1, 0, 2);

        // Abort a game while the dealer is drawing.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse(2);
        pulse(2);
        pulse(2);
        pulse(2);
        stay = 1'b1;
        card = 4'd5;
        wait_cnt = 0;
        while (!dhit && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        check("reach dhit", int'(dhit), 1);
        #2;
        reset = 1'b1;
        hit   = 1'b1;
        card  = 4'd15;
        #1;
        check("async rst", int'({win, lose, tie, dhit, dstay}), 0);
        repeat (3) @(negedge clk);
        check("rst hold", int'({win, lose, tie, dhit, dstay}), 0);
        reset = 1'b0;
        hit   = 1'b0;
        stay  = 1'b0;
        card  = 4'd0;

        // One held HIT gives one card; STAY beats a simultaneous HIT rise.
        p_q.delete();
        d_q.delete();
        play("hold", 5, 9, 5, 9, 1'b0, 1'b1, 1, 0, 0, 0, 2);

        // PS climbs past 63: clamped sum busts, a wrapped sum (20) would beat DS=18.
        p_q = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd9};
        d_q.delete();
        play("sat", 0, 9, 0, 9, 1'b0, 1'b0, 0, 1, 0, 0, 2);

        check("sb empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
